// File: rtl/census_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | census_window_gen                                                          |
// | Streaming WIN_H x WIN_W census signature generator with line buffers.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module census_window_gen #(
  parameter int PIX_W     = 8,
  parameter int IMG_WIDTH = 640,
  parameter int WIN_W     = 3,
  parameter int WIN_H     = 3,
  parameter int SIG_W     = WIN_W*WIN_H-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_border
);

  localparam int c_COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int c_ROW_W = $clog2(WIN_H);
  localparam int c_CY    = WIN_H/2;
  localparam int c_CX    = WIN_W/2;
  localparam int c_CIDX  = c_CY*WIN_W + c_CX;

  logic [c_COL_W-1:0] r_col;
  logic [c_COL_W-1:0] w_col;
  logic [c_COL_W-1:0] w_col_nxt;
  logic [c_ROW_W-1:0] r_row;
  logic [c_ROW_W-1:0] w_row;
  logic [c_ROW_W-1:0] w_row_nxt;
  logic               w_border;

  logic [PIX_W-1:0]   r_lb     [WIN_H-1][IMG_WIDTH];
  logic [PIX_W-1:0]   w_tap    [WIN_H-1];
  logic [PIX_W-1:0]   w_newcol [WIN_H];
  logic [PIX_W-1:0]   r_win    [WIN_H][WIN_W];

  logic               r_v1;
  logic               r_bord1;
  logic [SIG_W-1:0]   w_cmp;

  // in_sof relocates the accepted pixel to (0,0) regardless of the counters
  always_comb begin
    w_col     = in_sof ? '0 : r_col;
    w_row     = in_sof ? '0 : r_row;
    w_col_nxt = (w_col == c_COL_W'(IMG_WIDTH-1)) ? '0 : w_col + c_COL_W'(1);
    w_row_nxt = w_row;
    if ((w_col == c_COL_W'(IMG_WIDTH-1)) && (w_row != c_ROW_W'(WIN_H-1)))
      w_row_nxt = w_row + c_ROW_W'(1);
    w_border  = (w_row < c_ROW_W'(WIN_H-1)) || (w_col < c_COL_W'(WIN_W-1));
  end

  // Tap 0 is the previous row; higher taps are progressively older rows.
  always_comb begin
    for (int k = 0; k < WIN_H-1; k++)
      w_tap[k] = r_lb[k][w_col];
    for (int r = 0; r < WIN_H-1; r++)
      w_newcol[r] = w_tap[WIN_H-2-r];
    w_newcol[WIN_H-1] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      r_lb[0][w_col] <= in_pix;
      for (int k = 1; k < WIN_H-1; k++)
        r_lb[k][w_col] <= w_tap[k-1];
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W-1; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][WIN_W-1] <= w_newcol[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_v1    <= 1'b0;
      r_bord1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
        r_bord1 <= w_border;
      end
    end
  end

  // Raster-order comparison with the centre element removed from the index.
  for (genvar gr = 0; gr < WIN_H; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN_W; gc++) begin : g_col
      if (gr*WIN_W + gc < c_CIDX) begin : g_lo
        assign w_cmp[gr*WIN_W + gc] = (r_win[gr][gc] < r_win[c_CY][c_CX]);
      end else if (gr*WIN_W + gc > c_CIDX) begin : g_hi
        assign w_cmp[gr*WIN_W + gc - 1] = (r_win[gr][gc] < r_win[c_CY][c_CX]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sig    <= '0;
      out_border <= 1'b0;
    end else begin
      out_valid  <= r_v1;
      out_border <= r_v1 & r_bord1;
      out_sig    <= (r_v1 && !r_bord1) ? w_cmp : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_census_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_census_window_gen                                                       |
// | Scoreboard bench for census_window_gen (3x3 window, 8-pixel rows).         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_census_window_gen;

  localparam int IW = 8;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof   = 1'b0;
  logic [7:0] in_pix   = 8'h00;
  logic       out_valid;
  logic [7:0] out_sig;
  logic       out_border;

  census_window_gen #(
    .PIX_W(8), .IMG_WIDTH(IW), .WIN_W(3), .WIN_H(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(out_valid), .out_sig(out_sig), .out_border(out_border)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic [7:0] sig;
    logic       bord;
    int         t;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] img [0:15][0:IW-1];
  logic [7:0] hand [int];
  int         mrow = 0;
  int         mcol = 0;

  // Reference census over the bench's copy of the current frame
  function automatic logic [7:0] census(int r, int c);
    logic [7:0] s;
    logic [7:0] ctr;
    int         k;
    s   = 8'h00;
    ctr = img[r-1][c-1];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        k = dr*3 + dc;
        if (k < 4)      s[k]   = (img[r-2+dr][c-2+dc] < ctr);
        else if (k > 4) s[k-1] = (img[r-2+dr][c-2+dc] < ctr);
      end
    return s;
  endfunction

  function automatic logic [7:0] pixel(int kind, int v, int r, int c);
    case (kind)
      0:       return 8'd50;
      1:       return (r == 3 && c == 3) ? 8'(v) : 8'd100;
      default: return 8'((r*37 + c*53 + v*11) % 256);
    endcase
  endfunction

  task automatic send(input logic [7:0] p, input logic sof);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; in_pix = p;
    if (sof) begin mrow = 0; mcol = 0; end
    img[mrow][mcol] = p;
    e.bord = (mrow < 2) || (mcol < 2);
    e.sig  = e.bord ? 8'h00 : census(mrow, mcol);
    if (hand.exists(mrow*IW + mcol)) e.sig = hand[mrow*IW + mcol];
    e.t = cyc + 2;
    sb.push_back(e);
    if (mcol == IW-1) begin
      mcol = 0;
      if (mrow < 15) mrow++;
    end else mcol++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic send_frame(input int kind, input int v, input bit gap,
                            input bit sof, input int npix);
    int slot = 0;
    for (int i = 0; i < npix; i++) begin
      if (gap && (slot % 3 == 2)) begin
        idle(1);
        slot++;
      end
      send(pixel(kind, v, i / IW, i % IW), sof && (i == 0));
      slot++;
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    mrow = 0; mcol = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (rst_q) begin
      n_cmp++;
      if (out_valid !== 1'b0 || out_sig !== 8'h00 || out_border !== 1'b0) begin
        n_err++;
        $display("FAIL reset_out: got valid=%b sig=%h border=%b, required 0/00/0",
                 out_valid, out_sig, out_border);
      end
    end else if (out_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out @%0d: got sig=%h border=%b, none expected",
                 cyc, out_sig, out_border);
      end else begin
        mon_e = sb.pop_front();
        if (out_sig !== mon_e.sig || out_border !== mon_e.bord || cyc != mon_e.t) begin
          n_err++;
          $display("FAIL out: got sig=%h border=%b cycle=%0d, required sig=%h border=%b cycle=%0d",
                   out_sig, out_border, cyc, mon_e.sig, mon_e.bord, mon_e.t);
        end
      end
    end
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_out: got no out_valid by cycle %0d, required sig=%h border=%b at cycle %0d",
               cyc, mon_e.sig, mon_e.bord, mon_e.t);
    end
    if (rst === 1'b1)
      while (sb.size() > 0 && sb[$].t > cyc) void'(sb.pop_back());
  end

  initial begin
    // Reset held 3 cycles with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_pix = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    idle(3);

    send_frame(0, 0, 1'b0, 1'b1, 64);
    idle(4);

    hand[4*IW+4] = 8'hFF; hand[4*IW+5] = 8'h00;
    send_frame(1, 200, 1'b0, 1'b1, 64);
    idle(4);
    hand[4*IW+4] = 8'h00; hand[4*IW+5] = 8'h08;
    send_frame(1, 10, 1'b0, 1'b1, 64);
    idle(4);
    hand[4*IW+4] = 8'hFF; hand[4*IW+5] = 8'h00;
    send_frame(1, 200, 1'b1, 1'b1, 64);
    idle(4);
    hand.delete();

    // Partial frame up to (5,2), then in_sof lands on what would be (5,3)
    send_frame(2, 1, 1'b0, 1'b1, 5*IW + 3);
    send_frame(2, 7, 1'b0, 1'b1, 64);
    idle(4);

    // Reset during row 4, then a frame without in_sof
    send_frame(2, 3, 1'b0, 1'b1, 4*IW + 4);
    pulse_rst();
    send_frame(2, 9, 1'b0, 1'b0, 64);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
